counter_cell_arbiter: RTL and testbench
=======================================

Name: counter_cell_arbiter

Overview:
- Scheduler for the counter-increment datapath: collects plus/minus count pulses from external requesters (CDU X/Y/Z, PIPA X/Y/Z, shaft, trunnion).
- Holds each as a pending request in a per-channel counter cell and grants one fixed-priority request per memory-cycle boundary to the unprogrammed-sequence (PINC/MINC) stealer.
- Sits between the A24 input-conditioning logic and the sequence generator; provides the counter address and direction for the stolen cycle.

Parameters:
NCH, 8, number of requester channels (channel 0 highest priority)
ADDR_W, 6, width of counter address output
BASE_ADDR, 6'o32, counter address of channel 0; channel i maps to BASE_ADDR+i

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cnt_p  in  NCH  per-channel plus pulse, one clk wide, rising-edge meaningful
cnt_m  in  NCH  per-channel minus pulse, one clk wide
cyc_strobe  in  1  memory-cycle boundary strobe, one clk wide
inhibit  in  1  counter steal inhibit (instruction not interruptible this cycle)
gojam  in  1  synchronous clear of all cells and FSM
ack  in  1  sequencer has completed the stolen PINC/MINC cycle
grant_valid  out  1  a steal is granted and in progress
grant_addr  out  ADDR_W  counter address of granted channel
grant_dir  out  1  0 = PINC (increment), 1 = MINC (decrement)
pending  out  NCH  per-channel any-request-pending flags
lost  out  NCH  sticky per-channel lost-pulse flags

Behaviour:
- Reset (rst high, async): all cells IDLE, FSM ARB, grant_valid=0, grant_addr=0, grant_dir=0, pending=0, lost=0.
- gojam=1 on a clk edge: same state as reset, synchronously. gojam has priority over every other input.
- Per-channel cell states: IDLE, PEND_P, PEND_M.
  - IDLE + cnt_p -> PEND_P.
  - IDLE + cnt_m -> PEND_M.
  - IDLE + both -> IDLE (net zero).
  - PEND_P + cnt_m -> IDLE (cancel); PEND_M + cnt_p -> IDLE (cancel).
  - PEND_x + same-sign pulse -> stay PEND_x and set lost[i] (pulse dropped).
  - PEND_x + both pulses -> treat as cancel plus same-sign, i.e. stay PEND_x, no lost.
- lost[i] clears only on rst/gojam.
- pending[i] = cell i not IDLE. Registered state: pending reflects a pulse one clk after the pulse edge.
- FSM states: ARB, STEAL.
  - ARB: on cyc_strobe=1 with inhibit=0 and any pending, select the lowest index i. On that edge:
    - grant_addr <= BASE_ADDR+i;
    - grant_dir <= (cell i == PEND_M);
    - grant_valid <= 1;
    - cell i <= IDLE;
    - go to STEAL.
  - ARB: cyc_strobe with inhibit=1 or nothing pending -> stay ARB, no change.
  - STEAL: grant outputs held stable; cyc_strobe ignored. On ack=1: grant_valid <= 0, go to ARB. A cyc_strobe coinciding with ack is not used for arbitration; the next strobe is.
- Pulse on the granted channel in the grant edge: the consumed request is cleared first, then the pulse applies to IDLE, so the cell becomes pending again. No lost and no cancel against the consumed request.
- Pulses on any channel during STEAL are accumulated normally; channel under grant is IDLE.
- ack in ARB: ignored.
- At most one grant per cyc_strobe; latency from strobe to grant_valid = 1 clk.
- Starvation of low-priority channels is permitted (fixed priority, as hardware).

Decomposition:
- Package counter_arb_pkg: cell state enum (IDLE/PEND_P/PEND_M), FSM enum (ARB/STEAL), DIR_PINC/DIR_MINC constants.
- One sub-module: counter_cell (single channel state, pending, lost; inputs p, m, clear_grant, gojam). The top instantiates NCH of these plus the priority encoder and FSM.

Test Plan:
- Reset mid-STEAL: grant ch3, assert rst before ack -> all outputs 0, pending=0 immediately (async).
- Single request: cnt_p[2] pulse, then cyc_strobe -> next clk grant_valid=1, grant_addr=6'o34, grant_dir=0, pending[2]=0. ack -> grant_valid=0.
- Priority: cnt_m[5] and cnt_p[1] pending, strobe -> grant addr 6'o33 dir 0. ack, strobe -> addr 6'o37 dir 1.
- Cancel/lost: cnt_p[0] then cnt_m[0] -> pending[0]=0, strobe gives no grant. cnt_p[4] twice -> lost[4]=1, one grant only.
- Inhibit and STEAL hold: strobe with inhibit=1 and ch6 pending -> no grant. During STEAL, second strobe with ch0 pending -> no change until ack. Following strobe -> ch0 granted.
- Re-arm in grant edge: cnt_p[3] pending, cnt_p[3] pulse on grant edge -> grant ch3, pending[3]=1 after, lost[3]=0.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared types for the counter-increment scheduler: per-channel cell state,
// arbiter FSM state and the PINC/MINC direction encoding driven onto grant_dir.
package counter_arb_pkg;

  // Pending request held by one counter cell.
  typedef enum logic [1:0] {
    CELL_IDLE   = 2'd0,
    CELL_PEND_P = 2'd1,
    CELL_PEND_M = 2'd2
  } cell_state_t;

  // Arbiter: waiting for a cycle boundary, or holding a stolen cycle.
  typedef enum logic {
    FSM_ARB   = 1'b0,
    FSM_STEAL = 1'b1
  } fsm_state_t;

  // Direction of the stolen counter cycle.
  localparam logic DIR_PINC = 1'b0;
  localparam logic DIR_MINC = 1'b1;

endpackage : counter_arb_pkg

// File: rtl/counter_cell.sv
// One requester channel: holds a single pending plus/minus request, cancels
// opposite pulses, and flags same-sign pulses that arrive while one is held.
// clear_grant consumes the held request before this edge's pulses are applied.
module counter_cell
  import counter_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        p,
  input  logic        m,
  input  logic        clear_grant,
  input  logic        gojam,
  output cell_state_t state,
  output logic        pending,
  output logic        lost
);

  cell_state_t base_state;
  cell_state_t next_state;
  logic        set_lost;

  // Apply this edge's pulses on top of the state left after any grant consume.
  always_comb begin
    base_state = clear_grant ? CELL_IDLE : state;
    next_state = base_state;
    set_lost   = 1'b0;
    case (base_state)
      CELL_IDLE: begin
        // Both pulses together net to zero and leave the cell idle.
        if (p && !m)      next_state = CELL_PEND_P;
        else if (m && !p) next_state = CELL_PEND_M;
      end
      CELL_PEND_P: begin
        // Both pulses: cancel plus re-arm, which is the same as holding.
        if (m && !p)      next_state = CELL_IDLE;
        else if (p && !m) set_lost   = 1'b1;
      end
      CELL_PEND_M: begin
        if (p && !m)      next_state = CELL_IDLE;
        else if (m && !p) set_lost   = 1'b1;
      end
      default: next_state = CELL_IDLE;
    endcase
  end

  // Cell state and sticky lost flag; gojam clears like reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CELL_IDLE;
      lost  <= 1'b0;
    end else if (gojam) begin
      state <= CELL_IDLE;
      lost  <= 1'b0;
    end else begin
      state <= next_state;
      lost  <= lost | set_lost;
    end
  end

  // Any held request counts as pending.
  always_comb begin
    pending = (state != CELL_IDLE);
  end

endmodule : counter_cell

// File: rtl/counter_cell_arbiter.sv
// Collects counter pulses into per-channel cells and grants the lowest-index
// pending channel to the PINC/MINC stealer on each usable cycle boundary.
// Grant appears one clk after the strobe and is held until ack.
module counter_cell_arbiter
  import counter_arb_pkg::*;
#(
  parameter int                NCH       = 8,
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(6'o32)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    cnt_p,
  input  logic [NCH-1:0]    cnt_m,
  input  logic              cyc_strobe,
  input  logic              inhibit,
  input  logic              gojam,
  input  logic              ack,
  output logic              grant_valid,
  output logic [ADDR_W-1:0] grant_addr,
  output logic              grant_dir,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    lost
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  cell_state_t       cell_st [NCH];
  logic [NCH-1:0]    clear_grant;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_pending;
  logic              arb_win;
  logic              take;
  fsm_state_t        state_q;
  fsm_state_t        state_d;

  // Per-channel request cells.
  for (genvar g = 0; g < NCH; g++) begin : g_cell
    counter_cell u_cell (
      .clk         (clk),
      .rst         (rst),
      .p           (cnt_p[g]),
      .m           (cnt_m[g]),
      .clear_grant (clear_grant[g]),
      .gojam       (gojam),
      .state       (cell_st[g]),
      .pending     (pending[g]),
      .lost        (lost[g])
    );
  end

  // Fixed-priority encoder: scanning downward leaves the lowest pending index.
  always_comb begin
    sel_idx     = '0;
    any_pending = |pending;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  // A usable boundary: strobe, not inhibited, something waiting.
  always_comb begin
    arb_win = cyc_strobe && !inhibit && any_pending;
  end

  // FSM state register; gojam returns to ARB like reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state_q <= FSM_ARB;
    else if (gojam) state_q <= FSM_ARB;
    else            state_q <= state_d;
  end

  // FSM next state: strobes are ignored while a steal is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FSM_ARB:   if (arb_win) state_d = FSM_STEAL;
      FSM_STEAL: if (ack)     state_d = FSM_ARB;
      default:   state_d = FSM_ARB;
    endcase
  end

  // FSM outputs: grant flag and the one-hot consume of the winning cell.
  always_comb begin
    take        = (state_q == FSM_ARB) && arb_win;
    clear_grant = '0;
    if (take) clear_grant[sel_idx] = 1'b1;
    grant_valid = (state_q == FSM_STEAL);
  end

  // Latch the winner's address and direction on the grant edge; held after ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_addr <= '0;
      grant_dir  <= DIR_PINC;
    end else if (gojam) begin
      grant_addr <= '0;
      grant_dir  <= DIR_PINC;
    end else if (take) begin
      grant_addr <= BASE_ADDR + ADDR_W'(sel_idx);
      grant_dir  <= (cell_st[sel_idx] == CELL_PEND_M) ? DIR_MINC : DIR_PINC;
    end
  end

endmodule : counter_cell_arbiter

// File: tb/tb_counter_cell_arbiter.sv
// Directed bench for counter_cell_arbiter with a signed-count reference model
// compared every falling edge, plus literal expectations for key scenarios.
module tb_counter_cell_arbiter;

  localparam int NCH  = 8;
  localparam int BASE = 26;  // 6'o32

  logic           clk;
  logic           rst;
  logic [NCH-1:0] cnt_p;
  logic [NCH-1:0] cnt_m;
  logic           cyc_strobe;
  logic           inhibit;
  logic           gojam;
  logic           ack;
  logic           grant_valid;
  logic [5:0]     grant_addr;
  logic           grant_dir;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] lost;

  int errors = 0;
  int checks = 0;

  counter_cell_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_p       (cnt_p),
    .cnt_m       (cnt_m),
    .cyc_strobe  (cyc_strobe),
    .inhibit     (inhibit),
    .gojam       (gojam),
    .ack         (ack),
    .grant_valid (grant_valid),
    .grant_addr  (grant_addr),
    .grant_dir   (grant_dir),
    .pending     (pending),
    .lost        (lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each channel is a signed count in {-1,0,+1}.
  int             mv [NCH];
  bit [NCH-1:0]   mlost;
  bit             mbusy;
  int             maddr;
  bit             mdir;
  int             msel;
  int             mdelta;

  always @(posedge clk or posedge rst) begin
    if (rst || gojam) begin
      for (int i = 0; i < NCH; i++) mv[i] = 0;
      mlost = '0;
      mbusy = 1'b0;
      maddr = 0;
      mdir  = 1'b0;
    end else begin
      msel = -1;
      for (int i = 0; i < NCH; i++) if (msel < 0 && mv[i] != 0) msel = i;
      if (!mbusy) begin
        if (cyc_strobe && !inhibit && msel >= 0) begin
          maddr    = BASE + msel;
          mdir     = (mv[msel] < 0);
          mv[msel] = 0;
          mbusy    = 1'b1;
        end
      end else if (ack) begin
        mbusy = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        mdelta = int'(cnt_p[i]) - int'(cnt_m[i]);
        if (mdelta != 0) begin
          if (mv[i] == 0)            mv[i] = mdelta;
          else if (mv[i] == -mdelta) mv[i] = 0;
          else                       mlost[i] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  logic [NCH-1:0] exp_pend;
  always @(negedge clk) begin
    exp_pend = '0;
    for (int i = 0; i < NCH; i++) exp_pend[i] = (mv[i] != 0);
    checks++;
    if (grant_valid !== mbusy || pending !== exp_pend || lost !== mlost ||
        grant_addr !== 6'(maddr) || grant_dir !== mdir) begin
      errors++;
      $display("FAIL model t=%0t: got valid=%0b addr=%0d dir=%0b pend=%b lost=%b, want valid=%0b addr=%0d dir=%0b pend=%b lost=%b",
               $time, grant_valid, grant_addr, grant_dir, pending, lost,
               mbusy, maddr, mdir, exp_pend, mlost);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one clock of inputs, then return them to idle just after the edge.
  task automatic cyc(input logic [NCH-1:0] p, input logic [NCH-1:0] m,
                     input logic s, input logic inh, input logic a, input logic gj);
    cnt_p = p; cnt_m = m; cyc_strobe = s; inhibit = inh; ack = a; gojam = gj;
    @(posedge clk);
    #1;
    cnt_p = '0; cnt_m = '0; cyc_strobe = 1'b0; inhibit = 1'b0; ack = 1'b0; gojam = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cnt_p = '0; cnt_m = '0; cyc_strobe = 1'b0;
    inhibit = 1'b0; gojam = 1'b0; ack = 1'b0;
    #12;
    chk("reset_valid", 32'(grant_valid), 0);
    chk("reset_addr",  32'(grant_addr), 0);
    chk("reset_pend",  32'(pending), 0);
    chk("reset_lost",  32'(lost), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request on ch2.
    cyc(8'h04, 8'h00, 0, 0, 0, 0);
    chk("single_pend", 32'(pending), 32'h04);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("single_valid", 32'(grant_valid), 1);
    chk("single_addr",  32'(grant_addr), 28);
    chk("single_dir",   32'(grant_dir), 0);
    chk("single_pend2", 32'(pending), 0);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);
    chk("single_ack", 32'(grant_valid), 0);

    // Priority: ch1 plus beats ch5 minus.
    cyc(8'h02, 8'h20, 0, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("prio1_addr", 32'(grant_addr), 27);
    chk("prio1_dir",  32'(grant_dir), 0);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("prio2_addr", 32'(grant_addr), 31);
    chk("prio2_dir",  32'(grant_dir), 1);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);

    // Cancel on ch0, then lost on ch4.
    cyc(8'h01, 8'h00, 0, 0, 0, 0);
    cyc(8'h00, 8'h01, 0, 0, 0, 0);
    chk("cancel_pend", 32'(pending), 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("cancel_nogrant", 32'(grant_valid), 0);
    cyc(8'h10, 8'h00, 0, 0, 0, 0);
    cyc(8'h10, 8'h00, 0, 0, 0, 0);
    chk("lost4", 32'(lost), 32'h10);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("lost_grant_addr", 32'(grant_addr), 30);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("lost_one_grant", 32'(grant_valid), 0);

    // Inhibit, then STEAL ignores strobes until ack.
    cyc(8'h40, 8'h00, 0, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 1, 0, 0);
    chk("inhibit_nogrant", 32'(grant_valid), 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("ch6_addr", 32'(grant_addr), 32);
    cyc(8'h01, 8'h00, 0, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("steal_hold_addr", 32'(grant_addr), 32);
    chk("steal_hold_pend", 32'(pending), 32'h01);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);
    chk("steal_ack", 32'(grant_valid), 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("ch0_addr", 32'(grant_addr), 26);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);

    // Strobe coinciding with ack is not used for arbitration.
    cyc(8'h06, 8'h00, 0, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("ackstb_first", 32'(grant_addr), 27);
    cyc(8'h00, 8'h00, 1, 0, 1, 0);
    chk("ackstb_valid", 32'(grant_valid), 0);
    chk("ackstb_pend",  32'(pending), 32'h04);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("ackstb_next", 32'(grant_addr), 28);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);

    // Re-arm on the grant edge.
    cyc(8'h08, 8'h00, 0, 0, 0, 0);
    cyc(8'h08, 8'h00, 1, 0, 0, 0);
    chk("rearm_addr", 32'(grant_addr), 29);
    chk("rearm_pend", 32'(pending), 32'h08);
    chk("rearm_lost", 32'(lost[3]), 0);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("rearm_regrant", 32'(grant_addr), 29);
    cyc(8'h00, 8'h00, 0, 0, 1, 0);

    // Both pulses on an idle cell net to zero; ack in ARB is harmless.
    cyc(8'h20, 8'h20, 0, 0, 1, 0);
    chk("both_idle", 32'(pending), 0);

    // gojam during STEAL overrides a coincident pulse.
    cyc(8'h80, 8'h00, 0, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("ch7_addr", 32'(grant_addr), 33);
    cyc(8'h01, 8'h00, 0, 0, 0, 1);
    chk("gojam_valid", 32'(grant_valid), 0);
    chk("gojam_pend",  32'(pending), 0);
    chk("gojam_lost",  32'(lost), 0);
    chk("gojam_addr",  32'(grant_addr), 0);

    // Async reset in the middle of a steal.
    cyc(8'h28, 8'h00, 0, 0, 0, 0);
    cyc(8'h00, 8'h00, 1, 0, 0, 0);
    chk("rst_pre_addr", 32'(grant_addr), 29);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(grant_valid), 0);
    chk("rst_async_addr",  32'(grant_addr), 0);
    chk("rst_async_pend",  32'(pending), 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(8'h00, 8'h00, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter_cell_arbiter
